rc4_xor_engine: RTL and testbench
=================================

Name: rc4_xor_engine

Overview:
- Consumer side of the RC4 keystream interface: requests keystream bytes from the RC4 core after key setup, buffers them, and XORs them with a byte stream.
- The same XOR serves encryption and decryption.
- Sits between the RC4 core (ks_req/ks_valid) and the datapath (valid/ready in and out).
- Processes one message of msg_len bytes per start.

Parameters:
KS_DEPTH, 4, keystream FIFO depth; power of 2, >=2
LEN_W, 16, width of message length and byte counters

Ports:
clk  in  1  clock
rst_n  in  1  reset, synchronous, active-low
start  in  1  begin message; sampled only in IDLE
msg_len  in  LEN_W  message length in bytes; latched on accepted start
key_ready  in  1  RC4 core has finished key setup (KSA)
busy  out  1  high whenever state != IDLE
done  out  1  one-cycle pulse at message end
ks_req  out  1  request one keystream byte per asserted cycle
ks_valid  in  1  keystream byte returned this cycle
ks_byte  in  8  keystream byte
in_valid  in  1  input byte valid
in_data  in  8  plaintext/ciphertext byte
in_ready  out  1  engine accepts in_data this cycle
out_valid  out  1  output byte valid
out_data  out  8  in_data XOR keystream
out_ready  in  1  downstream accepts out_data
byte_cnt  out  LEN_W  bytes accepted on input in the current message

Behaviour:
- Reset: state IDLE. busy, done, ks_req, in_ready, out_valid are 0. out_data and byte_cnt are 0. FIFO is empty, outstanding=0, req_cnt=0. Reset mid-message discards all state; no done pulse is produced.
- States: IDLE, WAIT_KEY, RUN, FLUSH.
- IDLE:
  - start with msg_len=0: done=1 on the next cycle; state stays IDLE; busy stays 0.
  - start with msg_len>0: latch msg_len; clear byte_cnt and req_cnt; go to WAIT_KEY.
- start outside IDLE is ignored.
- WAIT_KEY: ks_req=0 and in_ready=0 until key_ready=1, then go to RUN on the next cycle.
- ks_req is combinational and asserted in RUN when all of the following hold:
  - fifo_count + outstanding < KS_DEPTH
  - req_cnt < msg_len
- outstanding counts requests not yet answered:
  - +1 on ks_req; -1 on ks_valid; unchanged when both occur in the same cycle.
  - ks_valid with outstanding=0 is dropped; the FIFO is not written.
- ks_valid writes ks_byte to the FIFO. Write and pop in the same cycle leave fifo_count unchanged. The credit rule above makes FIFO overflow impossible.
- in_ready, combinational, asserted when all of the following hold:
  - state = RUN
  - FIFO not empty
  - byte_cnt < msg_len
  - out_valid=0 or out_ready=1
- Input handshake (in_valid & in_ready):
  - out_data <= in_data ^ fifo_head; out_valid <= 1.
  - Pop the FIFO; byte_cnt++.
  - Latency input to output is 1 cycle; throughput is 1 byte/cycle.
- Output accepted with no new input handshake: out_valid <= 0. out_data holds its value while out_valid=1 and out_ready=0.
- After the handshake that takes byte_cnt to msg_len: go to FLUSH.
- FLUSH: when out_valid & out_ready, issue a done pulse and go to IDLE. The FIFO is empty at this point because exactly msg_len bytes were requested.
- byte_cnt holds its final value in IDLE until the next start.

Decomposition:
- Shared package rc4_pkg: state enum (IDLE, WAIT_KEY, RUN, FLUSH) and BYTE_W=8.
- Sub-module rc4_ks_fifo: synchronous FIFO, KS_DEPTH x 8.
  - Ports: push, pop, head, count.
  - Supports push and pop in the same cycle.
  - Cleared by rst_n.

Test Plan:
- start, msg_len=0 -> done=1 exactly 1 cycle later; ks_req, busy, in_ready never asserted.
- KS_DEPTH=4, msg_len=3, key_ready=1, core answers each ks_req 1 cycle later with A5,3C,FF; inputs 00,FF,3C -> outputs A5,C3,C3 in order; exactly 3 ks_req; done pulse after last out accept; byte_cnt=3.
- Backpressure: msg_len=8, core answers immediately, out_ready=0 for 5 cycles -> out_data stable, in_ready=0, ks_req stops once fifo_count+outstanding=4; resuming loses and duplicates nothing (8 outputs, 8 requests).
- key_ready held 0 for 10 cycles after start -> busy=1, ks_req=0, in_ready=0 throughout; RUN entered on the cycle after key_ready rises.
- rst_n=0 after 2 of 8 bytes -> all outputs 0 next cycle, no done; a new start with msg_len=2 completes with byte_cnt=2.
- With FIFO at KS_DEPTH-1, ks_valid coincides with a pop -> count unchanged; start pulsed during RUN -> ignored; ks_valid with outstanding=0 -> no FIFO write.

Source files
------------

// File: rtl/rc4_pkg.sv
// Shared definitions for the RC4 keystream consumer.
//   state_e : engine control states
//   BYTE_W  : datapath byte width
package rc4_pkg;

  localparam int unsigned BYTE_W = 8;

  typedef enum logic [1:0] {
    StIdle,
    StWaitKey,
    StRun,
    StFlush
  } state_e;

endpackage

// File: rtl/rc4_xor_engine_if.sv
// Handshake bundle of the XOR engine: keystream link to the RC4 core plus the
// input and output byte streams.
//   slave  : engine side (drives ks_req, in_ready, out_valid, out_data)
//   master : environment side (RC4 core, upstream source, downstream sink)
interface rc4_xor_engine_if;
  import rc4_pkg::*;

  logic              ks_req;
  logic              ks_valid;
  logic [BYTE_W-1:0] ks_byte;
  logic              in_valid;
  logic [BYTE_W-1:0] in_data;
  logic              in_ready;
  logic              out_valid;
  logic [BYTE_W-1:0] out_data;
  logic              out_ready;

  modport slave (
    output ks_req,
    input  ks_valid,
    input  ks_byte,
    input  in_valid,
    input  in_data,
    output in_ready,
    output out_valid,
    output out_data,
    input  out_ready
  );

  modport master (
    input  ks_req,
    output ks_valid,
    output ks_byte,
    output in_valid,
    output in_data,
    input  in_ready,
    input  out_valid,
    input  out_data,
    output out_ready
  );

endinterface

// File: rtl/rc4_ks_fifo.sv
// Keystream FIFO, DEPTH x BYTE_W, synchronous reset.
//   clk, rst_n : clock, synchronous active-low reset (clears pointers/count)
//   i_push     : write i_data this cycle
//   i_pop      : drop the head entry this cycle
//   o_head     : oldest stored byte
//   o_count    : number of stored bytes (0..DEPTH)
// Push and pop may occur in the same cycle. Caller guarantees no overflow
// and no pop when empty.
module rc4_ks_fifo
  import rc4_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  localparam int unsigned PtrW = $clog2(DEPTH),
  localparam int unsigned CntW = PtrW + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_push,
  input  logic [BYTE_W-1:0] i_data,
  input  logic              i_pop,
  output logic [BYTE_W-1:0] o_head,
  output logic [CntW-1:0]   o_count
);

  logic [BYTE_W-1:0] r_mem [DEPTH];
  logic [PtrW-1:0]   r_wptr;
  logic [PtrW-1:0]   r_rptr;
  logic [CntW-1:0]   r_count;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (i_push) r_wptr <= r_wptr + PtrW'(1);
      if (i_pop)  r_rptr <= r_rptr + PtrW'(1);
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + CntW'(1);
        2'b01:   r_count <= r_count - CntW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset: count gates every read.
  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wptr] <= i_data;
  end

  assign o_head  = r_mem[r_rptr];
  assign o_count = r_count;

endmodule

// File: rtl/rc4_xor_engine.sv
// RC4 keystream consumer: after key setup, requests one keystream byte per
// message byte from the RC4 core, buffers them in a small FIFO and XORs them
// with the incoming byte stream (same operation encrypts and decrypts).
//   clk, rst_n  : clock, synchronous active-low reset
//   i_start     : begin a message (sampled only in idle)
//   i_msg_len   : message length in bytes, latched on accepted start
//   i_key_ready : RC4 core finished key setup
//   o_busy      : engine not idle
//   o_done      : one-cycle pulse at message end
//   o_byte_cnt  : bytes accepted on input in the current message
//   bus         : keystream request/return, input stream, output stream
module rc4_xor_engine
  import rc4_pkg::*;
#(
  parameter int unsigned KS_DEPTH = 4,
  parameter int unsigned LEN_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_start,
  input  logic [LEN_W-1:0] i_msg_len,
  input  logic             i_key_ready,
  output logic             o_busy,
  output logic             o_done,
  output logic [LEN_W-1:0] o_byte_cnt,
  rc4_xor_engine_if.slave  bus
);

  localparam int unsigned CntW  = $clog2(KS_DEPTH) + 1;
  localparam int unsigned InflW = CntW + 1;

  state_e            r_state;
  state_e            w_state_next;
  logic [LEN_W-1:0]  r_len;
  logic [LEN_W-1:0]  r_byte_cnt;
  logic [LEN_W-1:0]  r_req_cnt;
  logic [CntW-1:0]   r_outstanding;
  logic [BYTE_W-1:0] r_out_data;
  logic              r_out_valid;
  logic              r_done;

  logic [CntW-1:0]   w_fifo_count;
  logic [BYTE_W-1:0] w_fifo_head;
  logic [InflW-1:0]  w_inflight;
  logic              w_credit_ok;
  logic              w_ks_accept;
  logic              w_ks_req;
  logic              w_in_ready;
  logic              w_in_fire;
  logic              w_out_fire;
  logic              w_last;
  logic              w_start_ok;
  logic              w_busy;

  // Stored plus requested-but-unanswered bytes must fit in the FIFO, so a
  // returning keystream byte always has a free slot.
  assign w_inflight  = {1'b0, w_fifo_count} + {1'b0, r_outstanding};
  assign w_credit_ok = w_inflight < InflW'(KS_DEPTH);

  // A return with nothing outstanding is spurious and is dropped.
  assign w_ks_accept = bus.ks_valid && (r_outstanding != '0);
  assign w_in_fire   = bus.in_valid && w_in_ready;
  assign w_out_fire  = r_out_valid && bus.out_ready;
  assign w_last      = w_in_fire && (r_byte_cnt == r_len - LEN_W'(1));
  assign w_start_ok  = (r_state == StIdle) && i_start;

  rc4_ks_fifo #(
    .DEPTH (KS_DEPTH)
  ) u_ks_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_ks_accept),
    .i_data  (bus.ks_byte),
    .i_pop   (w_in_fire),
    .o_head  (w_fifo_head),
    .o_count (w_fifo_count)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= StIdle;
    else        r_state <= w_state_next;
  end

  // Next-state logic.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:    if (i_start && (i_msg_len != '0)) w_state_next = StWaitKey;
      StWaitKey: if (i_key_ready)                  w_state_next = StRun;
      StRun:     if (w_last)                       w_state_next = StFlush;
      StFlush:   if (w_out_fire)                   w_state_next = StIdle;
      default:                                     w_state_next = StIdle;
    endcase
  end

  // State-decoded outputs.
  always_comb begin
    w_busy     = (r_state != StIdle);
    w_ks_req   = 1'b0;
    w_in_ready = 1'b0;
    if (r_state == StRun) begin
      w_ks_req   = w_credit_ok && (r_req_cnt < r_len);
      w_in_ready = (w_fifo_count != '0) && (r_byte_cnt < r_len) &&
                   (!r_out_valid || bus.out_ready);
    end
  end

  // Datapath and counters.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_len         <= '0;
      r_byte_cnt    <= '0;
      r_req_cnt     <= '0;
      r_outstanding <= '0;
      r_out_data    <= '0;
      r_out_valid   <= 1'b0;
      r_done        <= 1'b0;
    end else begin
      r_done <= 1'b0;

      if (w_start_ok) begin
        if (i_msg_len == '0) begin
          r_done <= 1'b1;
        end else begin
          r_len      <= i_msg_len;
          r_byte_cnt <= '0;
          r_req_cnt  <= '0;
        end
      end

      if (w_ks_req) r_req_cnt <= r_req_cnt + LEN_W'(1);

      if (w_ks_req && !w_ks_accept) begin
        r_outstanding <= r_outstanding + CntW'(1);
      end else if (!w_ks_req && w_ks_accept) begin
        r_outstanding <= r_outstanding - CntW'(1);
      end

      if (w_in_fire) begin
        r_out_data  <= bus.in_data ^ w_fifo_head;
        r_out_valid <= 1'b1;
        r_byte_cnt  <= r_byte_cnt + LEN_W'(1);
      end else if (w_out_fire) begin
        r_out_valid <= 1'b0;
      end

      if ((r_state == StFlush) && w_out_fire) r_done <= 1'b1;
    end
  end

  assign bus.ks_req    = w_ks_req;
  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;
  assign o_busy        = w_busy;
  assign o_done        = r_done;
  assign o_byte_cnt    = r_byte_cnt;

endmodule

// File: tb/tb_rc4_xor_engine.sv
// Self-checking bench for rc4_xor_engine. The bench plays the RC4 core, the
// upstream source and the downstream sink, and predicts every handshake from
// a queue-level model of the keystream, the outstanding requests and the
// pending output byte.
module tb_rc4_xor_engine;

  localparam int unsigned KS_DEPTH = 4;
  localparam int unsigned LEN_W    = 16;

  typedef struct {
    int len;
    int key_delay;
    int lat_min;
    int lat_max;
    int or_pct;
    int iv_pct;
    int stall_at;
    int stall_len;
    int spur;
    int start_noise;
    int abort_at;
    int exp_cnt;
  } vec_t;

  typedef struct {
    logic [7:0] ks;
    logic [7:0] din;
    logic [7:0] dout;
  } dir_t;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [LEN_W-1:0] msg_len = '0;
  logic             key_ready = 1'b0;
  logic             busy;
  logic             done;
  logic [LEN_W-1:0] byte_cnt;

  rc4_xor_engine_if bus ();

  rc4_xor_engine #(
    .KS_DEPTH (KS_DEPTH),
    .LEN_W    (LEN_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_start     (start),
    .i_msg_len   (msg_len),
    .i_key_ready (key_ready),
    .o_busy      (busy),
    .o_done      (done),
    .o_byte_cnt  (byte_cnt),
    .bus         (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [7:0] ks_q[$];
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  logic [7:0] fix_ks[$];
  logic [7:0] fix_in[$];
  int         due_q[$];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"},      int'(busy),          0);
    check({tag, "_done"},      int'(done),          0);
    check({tag, "_ks_req"},    int'(bus.ks_req),    0);
    check({tag, "_in_ready"},  int'(bus.in_ready),  0);
    check({tag, "_out_valid"}, int'(bus.out_valid), 0);
    check({tag, "_out_data"},  int'(bus.out_data),  0);
    check({tag, "_byte_cnt"},  int'(byte_cnt),      0);
  endtask

  task automatic drive_idle();
    start         = 1'b0;
    key_ready     = 1'b0;
    bus.ks_valid  = 1'b0;
    bus.ks_byte   = 8'h00;
    bus.in_valid  = 1'b0;
    bus.in_data   = 8'h00;
    bus.out_ready = 1'b0;
  endtask

  // One message from start to the cycle after done. Inputs change on the
  // falling edge; outputs are predicted and compared before the rising edge.
  task automatic run_msg(input vec_t v);
    int reqs, ins, outs, outst, outst_pre, ks_pre, last_due, c_last, lat;
    logic [7:0] b;
    logic exp_req, exp_rdy, stalled;
    bit finished, aborted;
    reqs = 0; ins = 0; outs = 0; outst = 0; last_due = -1; c_last = -1;
    finished = 1'b0; aborted = 1'b0;
    ks_q.delete(); exp_q.delete(); due_q.delete(); got_q.delete();
    @(negedge clk);
    start = 1'b1; msg_len = LEN_W'(v.len); key_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      if (c > 0) @(negedge clk);
      key_ready = (c >= v.key_delay);
      stalled   = (c >= v.stall_at) && (c < v.stall_at + v.stall_len);

      check("busy", int'(busy), int'((c_last < 0) || (c <= c_last)));
      check("done", int'(done), int'((c_last >= 0) && (c == c_last + 1)));
      check("byte_cnt", int'(byte_cnt), ins);
      check("out_valid", int'(bus.out_valid), int'(exp_q.size() != 0));
      if (exp_q.size() != 0) check("out_data", int'(bus.out_data), int'(exp_q[0]));
      if ((c_last >= 0) && (c == c_last + 2)) begin
        check("req_total", reqs, v.len);
        check("out_total", outs, v.len);
        check("byte_cnt_final", int'(byte_cnt), v.exp_cnt);
        finished = 1'b1;
        break;
      end

      // Keystream side: credit-limited requests, in-order returns.
      ks_pre    = ks_q.size();
      outst_pre = outst;
      exp_req   = (c > v.key_delay) && (reqs < v.len) && (ks_pre + outst_pre < int'(KS_DEPTH));
      check("ks_req", int'(bus.ks_req), int'(exp_req));
      if (bus.ks_req) begin
        reqs++;
        outst++;
        lat = int'($urandom_range(v.lat_max, v.lat_min));
        last_due = (c + lat > last_due + 1) ? c + lat : last_due + 1;
        due_q.push_back(last_due);
      end
      if ((due_q.size() != 0) && (due_q[0] <= c)) begin
        void'(due_q.pop_front());
        if (fix_ks.size() != 0) b = fix_ks.pop_front();
        else                    b = 8'($urandom);
        bus.ks_valid = 1'b1;
        bus.ks_byte  = b;
        ks_q.push_back(b);
        outst--;
      end else begin
        // Unsolicited return while nothing is outstanding must be ignored.
        bus.ks_valid = (v.spur != 0) && (outst_pre == 0) && ($urandom_range(99) < 30);
        bus.ks_byte  = 8'($urandom);
      end

      bus.out_ready = !stalled && ($urandom_range(99) < v.or_pct);
      bus.in_valid  = (ins < v.len) && ($urandom_range(99) < v.iv_pct);
      bus.in_data   = (fix_in.size() != 0) ? fix_in[0] : 8'($urandom);
      start   = (v.start_noise != 0) && (outs < v.len) && ($urandom_range(3) == 0);
      msg_len = LEN_W'($urandom);

      #1;
      exp_rdy = (c > v.key_delay) && (ks_pre != 0) && (ins < v.len) &&
                ((exp_q.size() == 0) || bus.out_ready);
      check("in_ready", int'(bus.in_ready), int'(exp_rdy));
      if (bus.out_valid && bus.out_ready) begin
        got_q.push_back(bus.out_data);
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        outs++;
        if (outs == v.len) c_last = c;
      end
      if (bus.in_valid && bus.in_ready) begin
        if (ks_q.size() != 0) exp_q.push_back(bus.in_data ^ ks_q.pop_front());
        else                  exp_q.push_back(bus.in_data);
        if (fix_in.size() != 0) void'(fix_in.pop_front());
        ins++;
        if ((v.abort_at != 0) && (ins == v.abort_at)) begin
          aborted  = 1'b1;
          finished = 1'b1;
          break;
        end
      end
    end
    if (!finished) begin
      checks++;
      errors++;
      $display("FAIL timeout: len %0d got ins=%0d outs=%0d reqs=%0d, required completion",
               v.len, ins, outs, reqs);
    end
    if (!aborted) drive_idle();
  endtask

  vec_t vecs[6];
  dir_t dir[3];
  vec_t rv;

  initial begin
    // Field order: len, key_delay, lat_min, lat_max, or_pct, iv_pct,
    //              stall_at, stall_len, spur, start_noise, abort_at, exp_cnt
    vecs[0] = '{8,  0,  1, 1, 100, 100, 4, 5, 0, 0, 0, 8};
    vecs[1] = '{4,  10, 1, 2, 100, 100, 0, 0, 0, 0, 0, 4};
    vecs[2] = '{1,  0,  1, 3, 70,  70,  0, 0, 1, 1, 0, 1};
    vecs[3] = '{4,  2,  3, 4, 100, 100, 0, 0, 1, 0, 0, 4};
    vecs[4] = '{20, 1,  1, 4, 60,  60,  6, 4, 1, 1, 0, 20};
    vecs[5] = '{12, 0,  1, 1, 100, 50,  3, 3, 1, 1, 0, 12};

    dir[0] = '{8'hA5, 8'h00, 8'hA5};
    dir[1] = '{8'h3C, 8'hFF, 8'hC3};
    dir[2] = '{8'hFF, 8'h3C, 8'hC3};

    drive_idle();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;

    // Zero-length message: done one cycle later, never busy.
    @(negedge clk);
    start = 1'b1; msg_len = '0;
    #1;
    check("zl_busy0",     int'(busy),         0);
    check("zl_ks_req0",   int'(bus.ks_req),   0);
    check("zl_in_ready0", int'(bus.in_ready), 0);
    @(negedge clk);
    start = 1'b0;
    check("zl_done1",   int'(done),         1);
    check("zl_busy1",   int'(busy),         0);
    check("zl_ks_req1", int'(bus.ks_req),   0);
    @(negedge clk);
    check("zl_done2", int'(done), 0);
    check("zl_busy2", int'(busy), 0);

    // Known keystream and data.
    for (int i = 0; i < 3; i++) begin
      fix_ks.push_back(dir[i].ks);
      fix_in.push_back(dir[i].din);
    end
    rv = '{3, 0, 1, 1, 100, 100, 0, 0, 0, 0, 0, 3};
    run_msg(rv);
    check("dir_count", got_q.size(), 3);
    for (int i = 0; i < 3; i++) begin
      if (i < got_q.size()) check($sformatf("dir_out%0d", i), int'(got_q[i]), int'(dir[i].dout));
    end
    fix_ks.delete();
    fix_in.delete();

    for (int i = 0; i < 6; i++) run_msg(vecs[i]);

    // Reset in the middle of a message: everything cleared, no done.
    rv = '{8, 0, 1, 1, 100, 100, 0, 0, 0, 0, 2, 0};
    run_msg(rv);
    @(negedge clk);
    rst_n = 1'b0;
    drive_idle();
    @(negedge clk);
    check_all_zero("midrst");
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("midrst_no_done", int'(done), 0);
    end
    rv = '{2, 0, 1, 2, 100, 100, 0, 0, 0, 0, 0, 2};
    run_msg(rv);

    // Randomised messages.
    for (int r = 0; r < 8; r++) begin
      rv.len         = int'($urandom_range(24, 1));
      rv.key_delay   = int'($urandom_range(3, 0));
      rv.lat_min     = 1;
      rv.lat_max     = int'($urandom_range(4, 1));
      rv.or_pct      = int'($urandom_range(100, 40));
      rv.iv_pct      = int'($urandom_range(100, 40));
      rv.stall_at    = int'($urandom_range(20, 0));
      rv.stall_len   = int'($urandom_range(6, 0));
      rv.spur        = 1;
      rv.start_noise = 1;
      rv.abort_at    = 0;
      rv.exp_cnt     = rv.len;
      run_msg(rv);
    end

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
